// File: rtl/fpga_cfg_pkg.sv
// Shared constants for the FPGA configuration controller: FSM encoding,
// CRC-16-CCITT parameters and the load-word width legality check.
package fpga_cfg_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_CLB  = 3'd1;
  localparam logic [2:0] ST_LOAD_CONN = 3'd2;
  localparam logic [2:0] ST_CHECK     = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERROR     = 3'd5;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic bit data_w_legal(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16);
  endfunction

endpackage

// File: rtl/fpga_cfg_ctrl_crc.sv
// Bit-serial CRC-16-CCITT (MSB-first shift, no reflection, no final XOR).
// Only present when FPGA_CFG_CRC_EN is defined.
`ifdef FPGA_CFG_CRC_EN
module crc16_serial
  import fpga_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[15] ^ bit_in;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`endif

// File: rtl/fpga_cfg_ctrl.sv
// Configuration controller: serialises a word stream onto the CLB then the
// connection scan chain; FPGA_CFG_CRC_EN adds a trailing CRC-16 check.
module fpga_cfg_ctrl
  import fpga_cfg_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CLB_LEN  = 2048,
  parameter int CONN_LEN = 4096,
  parameter int IO_W     = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              clb_scan_en,
  output logic              clb_scan_in,
  output logic              conn_scan_en,
  output logic              conn_scan_in,
  input  logic [IO_W-1:0]   fabric_out,
  output logic [IO_W-1:0]   fpga_out,
  output logic              fabric_reset,
  output logic [2:0]        dbg_state
);

  localparam int CLB_WORDS = CLB_LEN / DATA_W;
  localparam int TOT_WORDS = (CLB_LEN + CONN_LEN) / DATA_W;
  localparam int WCNT_W    = $clog2(TOT_WORDS + 1);
  localparam int REM_W     = $clog2(DATA_W) + 1;
  localparam logic [WCNT_W-1:0] CLB_LAST  = WCNT_W'(CLB_WORDS - 1);
  localparam logic [WCNT_W-1:0] WORDS_ALL = WCNT_W'(TOT_WORDS);
  localparam logic [REM_W-1:0]  REM_FULL  = REM_W'(DATA_W - 1);

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("fpga_cfg_ctrl: DATA_W must be 1, 2, 4, 8 or 16");
  end
  if ((CLB_LEN % DATA_W) != 0 || (CONN_LEN % DATA_W) != 0 || CLB_LEN < DATA_W || CONN_LEN < DATA_W)
  begin : g_bad_len
    $error("fpga_cfg_ctrl: chain lengths must be non-zero multiples of DATA_W");
  end

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              sel_conn_q, sel_conn_d;
  logic              scan_en_q, scan_en_d;
  logic              scan_in_q, scan_in_d;
  logic              in_load, accept, accept_payload, restart;

  // Handshake: a word moves on any cycle with cfg_valid && cfg_ready. Ready is
  // raised while the shifter is empty or presenting its last bit, so words can
  // stream back to back; valid may drop at any time and simply stalls the chain.
  assign in_load        = (state_q == ST_LOAD_CLB) || (state_q == ST_LOAD_CONN);
  assign cfg_ready      = (in_load && rem_q == '0 && wcnt_q != WORDS_ALL) || (state_q == ST_CHECK);
  assign accept         = cfg_valid && cfg_ready;
  assign accept_payload = accept && in_load;
  assign restart        = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);

`ifdef FPGA_CFG_CRC_EN
  localparam int CRC_WORDS = 16 / DATA_W;
  localparam int CHK_W     = $clog2(CRC_WORDS) + 1;
  localparam logic [CHK_W-1:0] CHK_LAST = CHK_W'(CRC_WORDS - 1);

  logic [CHK_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [15:0]      exp_crc_q, exp_crc_d, exp_next, word_ext, crc_val;
  logic             chk_last, crc_match;

  // CRC covers exactly the bits presented on the chains, in presentation order.
  crc16_serial u_crc (
    .clk    (clk),
    .reset  (reset),
    .clr    (restart),
    .en     (scan_en_q),
    .bit_in (scan_in_q),
    .crc    (crc_val)
  );

  always_comb begin
    word_ext  = 16'(cfg_data);
    exp_next  = exp_crc_q | (word_ext << (DATA_W * int'(chk_cnt_q)));
    chk_last  = accept && (state_q == ST_CHECK) && (chk_cnt_q == CHK_LAST);
    crc_match = (exp_next == crc_val);
    chk_cnt_d = chk_cnt_q;
    exp_crc_d = exp_crc_q;
    if (restart) begin
      chk_cnt_d = '0;
      exp_crc_d = '0;
    end else if (accept && state_q == ST_CHECK) begin
      chk_cnt_d = chk_cnt_q + CHK_W'(1);
      exp_crc_d = exp_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_cnt_q <= '0;
      exp_crc_q <= '0;
    end else begin
      chk_cnt_q <= chk_cnt_d;
      exp_crc_q <= exp_crc_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rem_d      = rem_q;
    wcnt_d     = wcnt_q;
    sel_conn_d = sel_conn_q;
    scan_en_d  = 1'b0;
    scan_in_d  = 1'b0;
    if (rem_q != '0) begin
      scan_en_d = 1'b1;
      scan_in_d = shift_q[0];
      shift_d   = shift_q >> 1;
      rem_d     = rem_q - REM_W'(1);
    end
    if (accept_payload) begin
      scan_en_d  = 1'b1;
      scan_in_d  = cfg_data[0];
      shift_d    = cfg_data >> 1;
      rem_d      = REM_FULL;
      sel_conn_d = (state_q == ST_LOAD_CONN);
      wcnt_d     = wcnt_q + WCNT_W'(1);
    end
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD_CLB;
          wcnt_d  = '0;
        end
      end
      ST_LOAD_CLB: begin
        if (accept_payload && wcnt_q == CLB_LAST) state_d = ST_LOAD_CONN;
      end
      ST_LOAD_CONN: begin
        // Leave only once the final word has fully drained onto the chain.
        if (wcnt_q == WORDS_ALL && rem_q == '0) begin
`ifdef FPGA_CFG_CRC_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef FPGA_CFG_CRC_EN
      ST_CHECK: begin
        if (chk_last) state_d = crc_match ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      rem_q      <= '0;
      wcnt_q     <= '0;
      sel_conn_q <= 1'b0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      rem_q      <= rem_d;
      wcnt_q     <= wcnt_d;
      sel_conn_q <= sel_conn_d;
      scan_en_q  <= scan_en_d;
      scan_in_q  <= scan_in_d;
    end
  end

  assign clb_scan_en  = scan_en_q & ~sel_conn_q;
  assign clb_scan_in  = scan_in_q & ~sel_conn_q;
  assign conn_scan_en = scan_en_q & sel_conn_q;
  assign conn_scan_in = scan_in_q & sel_conn_q;

  assign busy         = in_load || (state_q == ST_CHECK);
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERROR);
  assign fabric_reset = (state_q != ST_DONE);
  assign fpga_out     = (state_q == ST_DONE) ? fabric_out : '0;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fpga_cfg_ctrl.sv
// Self-checking bench for fpga_cfg_ctrl (DATA_W=8, 16+16 bit chains); builds
// with or without FPGA_CFG_CRC_EN.
`timescale 1ns/1ps
module tb_fpga_cfg_ctrl;

  localparam int DATA_W   = 8;
  localparam int CLB_LEN  = 16;
  localparam int CONN_LEN = 16;
  localparam int IO_W     = 20;
  localparam int NWORDS   = (CLB_LEN + CONN_LEN) / DATA_W;
  localparam int NBITS    = CLB_LEN + CONN_LEN;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic              cfg_ready, busy, done, error;
  logic              clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in;
  logic [IO_W-1:0]   fabric_out = '0;
  logic [IO_W-1:0]   fpga_out;
  logic              fabric_reset;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpga_cfg_ctrl #(
    .DATA_W(DATA_W), .CLB_LEN(CLB_LEN), .CONN_LEN(CONN_LEN), .IO_W(IO_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error),
    .clb_scan_en(clb_scan_en), .clb_scan_in(clb_scan_in),
    .conn_scan_en(conn_scan_en), .conn_scan_in(conn_scan_in),
    .fabric_out(fabric_out), .fpga_out(fpga_out),
    .fabric_reset(fabric_reset), .dbg_state(dbg_state)
  );

  // ---------------- chain monitor ----------------
  int   cyc = 0;
  logic obs_clb_q[$];
  logic obs_conn_q[$];
  int   en_cnt, first_en, last_en, done_cyc, bad_route, en_in_reset;
  logic prev_done = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (clb_scan_en) obs_clb_q.push_back(clb_scan_in);
    if (conn_scan_en) obs_conn_q.push_back(conn_scan_in);
    if (clb_scan_en || conn_scan_en) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      if (reset) en_in_reset++;
    end
    if ((clb_scan_en && conn_scan_en) || (!clb_scan_en && clb_scan_in) ||
        (!conn_scan_en && conn_scan_in)) bad_route++;
    if (done && !prev_done && done_cyc < 0) done_cyc = cyc;
    prev_done = done;
  end

  task automatic clear_mon();
    obs_clb_q.delete();
    obs_conn_q.delete();
    en_cnt = 0; first_en = -1; last_en = -1; done_cyc = -1;
    bad_route = 0; en_in_reset = 0; prev_done = done;
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] words[NWORDS];
  int                gaps[NWORDS];
  logic              exp_clb_q[$];
  logic              exp_conn_q[$];
`ifdef FPGA_CFG_CRC_EN
  int                flip_bit = -1;
`endif

  task automatic build_model();
    int n = 0;
    exp_clb_q.delete();
    exp_conn_q.delete();
    for (int w = 0; w < NWORDS; w++) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (n < CLB_LEN) exp_clb_q.push_back(words[w][b]);
        else exp_conn_q.push_back(words[w][b]);
        n++;
      end
    end
  endtask

`ifdef FPGA_CFG_CRC_EN
  function automatic logic [15:0] crc_model();
    logic [15:0] c = 16'hFFFF;
    logic        fb;
    for (int w = 0; w < NWORDS; w++) begin
      for (int b = 0; b < DATA_W; b++) begin
        fb = c[15] ^ words[w][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction
`endif

  function automatic int gap_sum();
    int s = 0;
    for (int i = 0; i < NWORDS - 1; i++) s += gaps[i];
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (!cfg_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cfg_ready) begin
      checks++; errors++;
      $display("FAIL %s ready_timeout cfg_ready=%b required 1", name, cfg_ready);
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    cfg_valid = 1'b1;
    cfg_data  = w;
    wait_ready("send_word");
    if (cfg_ready) @(negedge clk);
    cfg_valid = 1'b0;
    cfg_data  = DATA_W'($urandom);
  endtask

  task automatic send_stream(input bit start_mid);
`ifdef FPGA_CFG_CRC_EN
    logic [15:0] crc;
`endif
    for (int i = 0; i < NWORDS; i++) begin
      send_word(words[i]);
      if (start_mid && i == 1) do_start();
      if (i < NWORDS - 1 && gaps[i] > 0) begin
        wait_ready("gap");
        idle(gaps[i]);
      end
    end
`ifdef FPGA_CFG_CRC_EN
    crc = crc_model();
    if (flip_bit >= 0) crc = crc ^ (16'h0001 << flip_bit);
    for (int j = 0; j < 16 / DATA_W; j++) send_word(crc[j*DATA_W +: DATA_W]);
`endif
  endtask

  task automatic wait_finish(input string name);
    int t = 0;
    while (!(done || error) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL %s finish_timeout done=%b error=%b required completion", name, done, error);
    end
  endtask

  task automatic randomize_stream(input int max_gap);
    for (int i = 0; i < NWORDS; i++) begin
      words[i] = DATA_W'($urandom_range(255, 0));
      gaps[i]  = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    end
  endtask

  // Compares the observed chain traffic and final status against the model.
  task automatic check_stream(input string name, input int exp_span);
    int bad = 0;
    build_model();
    checks++;
    if (obs_clb_q.size() !== CLB_LEN) begin
      errors++; $display("FAIL %s clb_bits got=%0d required=%0d", name, obs_clb_q.size(), CLB_LEN);
    end
    checks++;
    if (obs_conn_q.size() !== CONN_LEN) begin
      errors++; $display("FAIL %s conn_bits got=%0d required=%0d", name, obs_conn_q.size(), CONN_LEN);
    end
    for (int i = 0; i < CLB_LEN && i < obs_clb_q.size(); i++)
      if (obs_clb_q[i] !== exp_clb_q[i]) bad++;
    for (int i = 0; i < CONN_LEN && i < obs_conn_q.size(); i++)
      if (obs_conn_q[i] !== exp_conn_q[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL %s bit_values wrong=%0d required 0", name, bad);
    end
    checks++;
    if (en_cnt !== NBITS) begin
      errors++; $display("FAIL %s enabled_cycles got=%0d required=%0d", name, en_cnt, NBITS);
    end
    checks++;
    if (last_en - first_en + 1 !== exp_span) begin
      errors++; $display("FAIL %s enable_span got=%0d required=%0d", name, last_en - first_en + 1, exp_span);
    end
    checks++;
    if (bad_route !== 0) begin
      errors++; $display("FAIL %s chain_routing violations=%0d required 0", name, bad_route);
    end
`ifndef FPGA_CFG_CRC_EN
    checks++;
    if (done_cyc !== last_en + 1) begin
      errors++; $display("FAIL %s done_timing got=%0d required=%0d", name, done_cyc, last_en + 1);
    end
`endif
    checks++;
    if ({done, error, busy, fabric_reset} !== 4'b1000) begin
      errors++; $display("FAIL %s status done/error/busy/frst got=%b required 1000", name,
                         {done, error, busy, fabric_reset});
    end
    fabric_out = IO_W'($urandom);
    #1;
    checks++;
    if (fpga_out !== fabric_out) begin
      errors++; $display("FAIL %s fpga_out got=%h required=%h", name, fpga_out, fabric_out);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    fabric_out = 20'hFFFFF;
    idle(3);
    reset = 1'b0;
    clear_mon();
    idle(10);
    checks++;
    if ({cfg_ready, done, error, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset status ready/done/error/busy got=%b required 0000",
                         {cfg_ready, done, error, busy});
    end
    checks++;
    if (fabric_reset !== 1'b1) begin
      errors++; $display("FAIL reset fabric_reset got=%b required 1", fabric_reset);
    end
    checks++;
    if (fpga_out !== '0) begin
      errors++; $display("FAIL reset fpga_out got=%h required 0", fpga_out);
    end
    checks++;
    if ({clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in} !== 4'b0000 || en_cnt !== 0) begin
      errors++; $display("FAIL reset scan got=%b en_cnt=%0d required 0000/0",
                         {clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in}, en_cnt);
    end
    checks++;
    if (dbg_state !== fpga_cfg_pkg::ST_IDLE) begin
      errors++; $display("FAIL reset state got=%0d required idle", dbg_state);
    end
  endtask

  task automatic test_continuous();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0; words[3] = 8'h0F;
    for (int i = 0; i < NWORDS; i++) gaps[i] = 0;
    clear_mon();
    do_start();
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL continuous ready_after_start ready=%b busy=%b required 1/1", cfg_ready, busy);
    end
    send_stream(1'b0);
    wait_finish("continuous");
    check_stream("continuous", NBITS);
  endtask

  task automatic test_gaps();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0; words[3] = 8'h0F;
    for (int i = 0; i < NWORDS; i++) gaps[i] = 3;
    clear_mon();
    do_start();
    send_stream(1'b0);
    wait_finish("gaps");
    check_stream("gaps", NBITS + gap_sum());
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      randomize_stream(4);
      clear_mon();
      do_start();
      send_stream(1'b0);
      wait_finish("random");
      check_stream("random", NBITS + gap_sum());
    end
  endtask

`ifdef FPGA_CFG_CRC_EN
  task automatic test_crc_bad();
    randomize_stream(2);
    flip_bit = $urandom_range(15, 0);
    fabric_out = IO_W'($urandom);
    clear_mon();
    do_start();
    send_stream(1'b0);
    wait_finish("crc_bad");
    flip_bit = -1;
    #1;
    checks++;
    if ({error, done, busy, fabric_reset} !== 4'b1001) begin
      errors++; $display("FAIL crc_bad status error/done/busy/frst got=%b required 1001",
                         {error, done, busy, fabric_reset});
    end
    checks++;
    if (fpga_out !== '0) begin
      errors++; $display("FAIL crc_bad fpga_out got=%h required 0", fpga_out);
    end
    clear_mon();
    do_start();
    checks++;
    if (error !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL crc_restart error=%b ready=%b required 0/1", error, cfg_ready);
    end
    send_stream(1'b0);
    wait_finish("crc_restart");
    check_stream("crc_restart", NBITS + gap_sum());
  endtask
`endif

  task automatic test_reset_mid();
    randomize_stream(0);
    clear_mon();
    do_start();
    send_word(words[0]);
    send_word(words[1]);
    reset = 1'b1;
    #1;
    checks++;
    if ({cfg_ready, busy, done, clb_scan_en, conn_scan_en, fabric_reset} !== 6'b000001) begin
      errors++; $display("FAIL reset_mid immediate got=%b required 000001",
                         {cfg_ready, busy, done, clb_scan_en, conn_scan_en, fabric_reset});
    end
    clear_mon();
    idle(4);
    checks++;
    if (en_in_reset !== 0 || en_cnt !== 0) begin
      errors++; $display("FAIL reset_mid scan_during_reset got=%0d required 0", en_cnt);
    end
    reset = 1'b0;
    idle(2);
    clear_mon();
    do_start();
    send_stream(1'b0);
    wait_finish("reset_mid");
    check_stream("reset_mid", NBITS);
  endtask

  task automatic test_start_ignored();
    randomize_stream(0);
    clear_mon();
    do_start();
    send_stream(1'b1);
    wait_finish("start_ignored");
    check_stream("start_ignored", NBITS);
  endtask

  task automatic test_restart_from_done();
    fabric_out = IO_W'($urandom) | IO_W'(1);
    #1;
    checks++;
    if (done !== 1'b1 || fpga_out !== fabric_out) begin
      errors++; $display("FAIL restart pre done=%b fpga_out=%h required 1/%h", done, fpga_out, fabric_out);
    end
    do_start();
    checks++;
    if ({done, busy, fabric_reset, cfg_ready} !== 4'b0111) begin
      errors++; $display("FAIL restart status done/busy/frst/ready got=%b required 0111",
                         {done, busy, fabric_reset, cfg_ready});
    end
    checks++;
    if (fpga_out !== '0) begin
      errors++; $display("FAIL restart fpga_out got=%h required 0", fpga_out);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_continuous();
    test_gaps();
    test_random();
`ifdef FPGA_CFG_CRC_EN
    test_crc_bad();
`endif
    test_reset_mid();
    test_start_ignored();
    test_restart_from_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
